ok_status_bank: RTL and testbench
=================================

Name: ok_status_bank

Overview:
Parametrised status/debug bank between FPGA_Bluetooth_connection and the Opal Kelly okWireOut endpoints. It replaces fixed per-endpoint wiring with NUM_CH channels that can be live or frozen, a snapshot counter, sticky error capture, and a scanning LED display. The top level instantiates one bank and slices wire_out into 16-bit okWireOut datain fields.

Parameters:
NUM_CH, 8, number of status channels (1..16)
WIDTH, 16, bits per channel (matches okWireOut datain)
STICKY_CH, 0, channel whose bits are OR-accumulated into sticky_out
LED_DWELL, 25000000, clock cycles per LED auto-scan step (>=2)

Ports:
clock  in  1  system clock
resetn  in  1  synchronous active-low reset
status_in  in  NUM_CH*WIDTH  live status words; channel k = [k*WIDTH +: WIDTH]
ctrl_in  in  16  control word from wireIn, synchronous to clock
wire_out  out  NUM_CH*WIDTH  words presented to okWireOut endpoints
sticky_out  out  WIDTH  accumulated set bits of channel STICKY_CH
snap_count  out  8  snapshots taken, wraps
snap_done  out  1  one-cycle pulse when a capture completes
ts_out  out  32  cycle timestamp of last capture (optional feature)
lights  out  8  active-low LED drive

Behaviour:
- Reset applies only when resetn=0 at a clock edge. It clears wire_out, sticky_out, snap_count, snap_done, ts_out and the dwell counter to 0, and the LED channel to 0. It sets lights to 8'hFF and the state to LIVE.
- ctrl_in bit map:
  - bit0 mode: 0 = live, 1 = frozen.
  - bit1 snap_req, rising-edge triggered.
  - bit2 clr_sticky, rising-edge triggered.
  - bits[7:4] led_sel.
  - bit8 led_auto.
  - Other bits are reserved and ignored.
- ctrl_in is registered once (ctrl_q). Edges are detected as ctrl_q & ~ctrl_qq, so effects apply 2 cycles after ctrl_in changes.
- FSM states: LIVE, FROZEN.
  - LIVE: wire_out <= status_in every cycle (1-cycle latency).
  - LIVE -> FROZEN when ctrl_q[0]=1. The transition itself performs a capture.
  - FROZEN: wire_out holds its value. A snap_req edge performs a capture.
  - FROZEN -> LIVE when ctrl_q[0]=0. No capture on this transition.
- Capture: wire_out <= status_in, snap_count += 1 (mod 256), snap_done = 1 for exactly one cycle.
  - A snap_req edge in LIVE also counts as a capture: snap_count increments and snap_done pulses.
  - A snap_req edge coinciding with the LIVE->FROZEN transition counts once, not twice.
- Sticky: every cycle, sticky_out <= sticky_out | status_in[STICKY_CH].
  - A clr_sticky edge loads sticky_out <= status_in[STICKY_CH], so bits set in the same cycle survive the clear.
- LEDs: lights = ~wire_out[ch*WIDTH +: 8], registered, where ch is the current LED channel.
  - led_auto=0: ch = led_sel. If led_sel >= NUM_CH, ch = NUM_CH-1.
  - led_auto=1: the dwell counter counts 0..LED_DWELL-1. At terminal count, ch advances by 1, wrapping NUM_CH-1 -> 0.
  - When led_auto falls to 0, the dwell counter resets to 0.
- Reset mid-capture: reset wins. No snap_done pulse is generated.

Optional Feature:
- Macro: OK_STATUS_TIMESTAMP_EN.
- Defined: a 32-bit free-running cycle counter (reset to 0, wraps) is latched into ts_out on every capture.
- Undefined: the counter is not built and ts_out is tied to 0.

Decomposition:
- Package ok_status_pkg holds:
  - ctrl bit-index constants CTRL_MODE=0, CTRL_SNAP=1, CTRL_CLR=2, CTRL_LSEL_LO=4, CTRL_LSEL_HI=7, CTRL_AUTO=8;
  - the state enum {ST_LIVE, ST_FROZEN};
  - OK_WORD_W=16.
- One sub-module, ok_led_scanner, contains the dwell counter, channel select and lights register. Its parameters are NUM_CH and LED_DWELL.

Test Plan:
- Reset: hold resetn=0 for 3 clocks with status_in nonzero -> wire_out=0, sticky_out=0, snap_count=0, lights=8'hFF.
- Live path: ctrl_in=0, set ch2=16'hBEEF -> wire_out[47:32]=16'hBEEF one cycle after status_in changes.
- Freeze/snapshot:
  - set ch0=16'h1234, ctrl_in=0x0001 -> snap_count=1, wire_out[15:0]=16'h1234;
  - change ch0=16'h5678 -> wire_out holds 16'h1234;
  - pulse bit1 -> wire_out[15:0]=16'h5678, snap_count=2, snap_done high for exactly one cycle.
- Sticky:
  - ch0 pulses 16'h0001 then 16'h0100 -> sticky_out=16'h0101;
  - clr_sticky edge while ch0=16'h0010 -> sticky_out=16'h0010.
- LED auto-scan:
  - LED_DWELL=4, NUM_CH=3, led_auto=1 -> displayed channel sequence 0,1,2,0 with 4 cycles per step;
  - ch1 low byte=8'h0F -> lights=8'hF0 during the ch1 step.
- Timestamp: with OK_STATUS_TIMESTAMP_EN defined, capture at cycle 100 after reset -> ts_out=100 (±register latency, to be fixed in the bench); with the macro undefined -> ts_out=0.

Source files
------------

// File: rtl/ok_status_pkg.sv
// Shared constants and types for the Opal Kelly status bank.
// Holds the ctrl_in bit positions, the bank state enum and word/LED widths.
package ok_status_pkg;

  localparam int OK_WORD_W = 16;
  localparam int LED_W     = 8;

  localparam int CTRL_MODE    = 0;
  localparam int CTRL_SNAP    = 1;
  localparam int CTRL_CLR     = 2;
  localparam int CTRL_LSEL_LO = 4;
  localparam int CTRL_LSEL_HI = 7;
  localparam int CTRL_AUTO    = 8;

  typedef enum logic {
    ST_LIVE,
    ST_FROZEN
  } state_e;

endpackage

// File: rtl/ok_led_scanner.sv
// LED display for the status bank: shows the low byte of one channel, active-low,
// either a fixed channel (clamped to the last one) or auto-scanning every LED_DWELL cycles.
module ok_led_scanner
  import ok_status_pkg::*;
#(
  parameter int NUM_CH    = 8,
  parameter int LED_DWELL = 25000000
) (
  input  logic                    clock,
  input  logic                    resetn,
  input  logic                    auto_en,
  input  logic [3:0]              led_sel,
  input  logic [NUM_CH*LED_W-1:0] led_bytes,
  output logic [LED_W-1:0]        lights
);

  localparam int              DW       = $clog2(LED_DWELL);
  localparam logic [DW-1:0]   DWELL_TC = DW'(LED_DWELL - 1);
  localparam logic [3:0]      LAST_CH  = 4'(NUM_CH - 1);

  logic [DW-1:0]    dwell_q, dwell_d;
  logic [3:0]       ch_q, ch_d;
  logic [LED_W-1:0] lights_q, lights_d;

  always_comb begin
    dwell_d = dwell_q;
    ch_d    = ch_q;
    if (auto_en) begin
      if (dwell_q == DWELL_TC) begin
        dwell_d = '0;
        ch_d    = (ch_q == LAST_CH) ? 4'd0 : ch_q + 4'd1;
      end else begin
        dwell_d = dwell_q + DW'(1);
      end
    end else begin
      // Leaving auto mode restarts the dwell so the next scan gets a full step.
      dwell_d = '0;
      ch_d    = ({1'b0, led_sel} >= 5'(NUM_CH)) ? LAST_CH : led_sel;
    end
    lights_d = ~led_bytes[int'(ch_q)*LED_W +: LED_W];
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      dwell_q  <= '0;
      ch_q     <= '0;
      lights_q <= '1;
    end else begin
      dwell_q  <= dwell_d;
      ch_q     <= ch_d;
      lights_q <= lights_d;
    end
  end

  assign lights = lights_q;

endmodule

// File: rtl/ok_status_bank.sv
// Status/debug bank feeding okWireOut: live/frozen channels, snapshot counter, sticky capture, LED scan.
// Optional OK_STATUS_TIMESTAMP_EN latches a free-running cycle count into ts_out on each capture.
module ok_status_bank
  import ok_status_pkg::*;
#(
  parameter int NUM_CH    = 8,
  parameter int WIDTH     = OK_WORD_W,
  parameter int STICKY_CH = 0,
  parameter int LED_DWELL = 25000000
) (
  input  logic                    clock,
  input  logic                    resetn,
  input  logic [NUM_CH*WIDTH-1:0] status_in,
  input  logic [15:0]             ctrl_in,
  output logic [NUM_CH*WIDTH-1:0] wire_out,
  output logic [WIDTH-1:0]        sticky_out,
  output logic [7:0]              snap_count,
  output logic                    snap_done,
  output logic [31:0]             ts_out,
  output logic [7:0]              lights
);

  localparam int CW = CTRL_AUTO + 1;

  logic [CW-1:0]              ctrl_q, ctrl_d;
  logic [CTRL_CLR:CTRL_SNAP]  ctrl_dly_q, ctrl_dly_d;
  state_e                     state_q, state_d;
  logic [NUM_CH*WIDTH-1:0]    wire_q, wire_d;
  logic [WIDTH-1:0]           sticky_q, sticky_d;
  logic [7:0]                 snap_count_q, snap_count_d;
  logic                       snap_done_q, snap_done_d;
  logic                       snap_edge, clr_edge, capture;
  logic [WIDTH-1:0]           sticky_in;
  logic [NUM_CH*LED_W-1:0]    led_bytes;
  logic                       unused_ctrl;

  assign unused_ctrl = ^{ctrl_in[15:CW], ctrl_q[3]};
  assign sticky_in   = status_in[STICKY_CH*WIDTH +: WIDTH];
  assign snap_edge   = ctrl_q[CTRL_SNAP] & ~ctrl_dly_q[CTRL_SNAP];
  assign clr_edge    = ctrl_q[CTRL_CLR]  & ~ctrl_dly_q[CTRL_CLR];

  always_comb begin
    ctrl_d     = ctrl_in[CW-1:0];
    ctrl_dly_d = ctrl_q[CTRL_CLR:CTRL_SNAP];
    state_d    = state_q;
    wire_d     = wire_q;
    capture    = 1'b0;
    unique case (state_q)
      ST_LIVE: begin
        wire_d = status_in;
        // Freezing already captures, so a coincident snap edge is not counted again.
        if (ctrl_q[CTRL_MODE]) begin
          state_d = ST_FROZEN;
          capture = 1'b1;
        end else if (snap_edge) begin
          capture = 1'b1;
        end
      end
      ST_FROZEN: begin
        if (!ctrl_q[CTRL_MODE]) begin
          state_d = ST_LIVE;
        end else if (snap_edge) begin
          wire_d  = status_in;
          capture = 1'b1;
        end
      end
      default: state_d = ST_LIVE;
    endcase
    snap_count_d = snap_count_q + {7'd0, capture};
    snap_done_d  = capture;
    sticky_d     = clr_edge ? sticky_in : (sticky_q | sticky_in);
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      ctrl_q       <= '0;
      ctrl_dly_q   <= '0;
      state_q      <= ST_LIVE;
      wire_q       <= '0;
      sticky_q     <= '0;
      snap_count_q <= '0;
      snap_done_q  <= 1'b0;
    end else begin
      ctrl_q       <= ctrl_d;
      ctrl_dly_q   <= ctrl_dly_d;
      state_q      <= state_d;
      wire_q       <= wire_d;
      sticky_q     <= sticky_d;
      snap_count_q <= snap_count_d;
      snap_done_q  <= snap_done_d;
    end
  end

`ifdef OK_STATUS_TIMESTAMP_EN
  logic [31:0] cyc_q, cyc_d, ts_q, ts_d;

  always_comb begin
    cyc_d = cyc_q + 32'd1;
    ts_d  = capture ? cyc_q : ts_q;
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      cyc_q <= '0;
      ts_q  <= '0;
    end else begin
      cyc_q <= cyc_d;
      ts_q  <= ts_d;
    end
  end

  assign ts_out = ts_q;
`else
  assign ts_out = '0;
`endif

  always_comb begin
    led_bytes = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      led_bytes[k*LED_W +: LED_W] = wire_q[k*WIDTH +: LED_W];
    end
  end

  ok_led_scanner #(
    .NUM_CH    (NUM_CH),
    .LED_DWELL (LED_DWELL)
  ) u_led_scanner (
    .clock     (clock),
    .resetn    (resetn),
    .auto_en   (ctrl_q[CTRL_AUTO]),
    .led_sel   (ctrl_q[CTRL_LSEL_HI:CTRL_LSEL_LO]),
    .led_bytes (led_bytes),
    .lights    (lights)
  );

  assign wire_out   = wire_q;
  assign sticky_out = sticky_q;
  assign snap_count = snap_count_q;
  assign snap_done  = snap_done_q;

endmodule

// File: tb/tb_ok_status_bank.sv
// Self-checking bench for ok_status_bank (3 channels, 4-cycle LED dwell).
// Captures are scoreboarded: expectations queued at stimulus, checked on snap_done.
module tb_ok_status_bank;

  localparam int NUM_CH = 3;
  localparam int WIDTH  = 16;

  logic                    clock;
  logic                    resetn;
  logic [NUM_CH*WIDTH-1:0] status_in;
  logic [15:0]             ctrl_in;
  logic [NUM_CH*WIDTH-1:0] wire_out;
  logic [WIDTH-1:0]        sticky_out;
  logic [7:0]              snap_count;
  logic                    snap_done;
  logic [31:0]             ts_out;
  logic [7:0]              lights;

  logic [15:0] st0, st1, st2;
  assign status_in = {st2, st1, st0};

  ok_status_bank #(
    .NUM_CH    (NUM_CH),
    .WIDTH     (WIDTH),
    .STICKY_CH (0),
    .LED_DWELL (4)
  ) dut (
    .clock      (clock),
    .resetn     (resetn),
    .status_in  (status_in),
    .ctrl_in    (ctrl_in),
    .wire_out   (wire_out),
    .sticky_out (sticky_out),
    .snap_count (snap_count),
    .snap_done  (snap_done),
    .ts_out     (ts_out),
    .lights     (lights)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, obs, exp);
    end
  endtask

  typedef struct {
    logic [7:0]  cnt;
    logic [15:0] w0;
  } cap_t;

  cap_t cap_q[$];
  cap_t cap_e;
  logic prev_done = 1'b0;

  task automatic push_cap(input logic [7:0] cnt, input logic [15:0] w0);
    cap_t c;
    c.cnt = cnt;
    c.w0  = w0;
    cap_q.push_back(c);
  endtask

`ifdef OK_STATUS_TIMESTAMP_EN
  logic [31:0] tb_cyc = '0;
  always @(posedge clock) tb_cyc <= resetn ? tb_cyc + 32'd1 : 32'd0;
`endif

  always @(negedge clock) begin
    if (resetn) begin
      if (snap_done) begin
        chk("done_1cyc", prev_done, 1'b0);
        chk("sb_pending", cap_q.size() != 0, 1'b1);
        if (cap_q.size() != 0) begin
          cap_e = cap_q.pop_front();
          chk("cap_cnt", snap_count, cap_e.cnt);
          chk("cap_w0", wire_out[15:0], cap_e.w0);
`ifdef OK_STATUS_TIMESTAMP_EN
          chk("cap_ts", ts_out, tb_cyc - 32'd1);
`else
          chk("cap_ts", ts_out, 32'd0);
`endif
        end
      end
      prev_done = snap_done;
    end else begin
      prev_done = 1'b0;
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  logic [7:0] rv[24];
  int         rl[24];
  int         nr;
  logic [7:0] s;

  initial begin
    #100000;
    $display("FAIL watchdog got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    resetn  = 1'b0;
    ctrl_in = 16'h0000;
    st0 = 16'h1111; st1 = 16'h2222; st2 = 16'h3333;
    repeat (3) @(posedge clock);
    @(negedge clock);
    chk("rst_wire", wire_out, '0);
    chk("rst_sticky", sticky_out, '0);
    chk("rst_cnt", snap_count, '0);
    chk("rst_lights", lights, 8'hFF);
    chk("rst_done", snap_done, 1'b0);
    chk("rst_ts", ts_out, '0);

    step(1);
    st0 = 16'h0; st1 = 16'h0; st2 = 16'h0;
    resetn = 1'b1;
    step(2);

    // live path latency
    st2 = 16'hBEEF;
    @(negedge clock);
    chk("live_early", wire_out[47:32], 16'h0000);
    @(negedge clock);
    chk("live", wire_out[47:32], 16'hBEEF);

    // freeze captures, then holds
    step(1);
    st0 = 16'h1234; ctrl_in = 16'h0001; push_cap(8'd1, 16'h1234);
    step(4);
    st0 = 16'h5678;
    step(3);
    @(negedge clock);
    chk("frozen_hold", wire_out[15:0], 16'h1234);
    chk("frozen_cnt", snap_count, 8'd1);

    step(1);
    ctrl_in = 16'h0003; push_cap(8'd2, 16'h5678);
    step(1);
    ctrl_in = 16'h0001;
    step(4);
    @(negedge clock);
    chk("snap_hold", wire_out[15:0], 16'h5678);

    // unfreeze: no capture, live again
    step(1);
    ctrl_in = 16'h0000;
    step(4);
    st0 = 16'h0042;
    step(2);
    @(negedge clock);
    chk("relive", wire_out[15:0], 16'h0042);
    chk("relive_cnt", snap_count, 8'd2);

    // snap in LIVE counts
    step(1);
    ctrl_in = 16'h0002; push_cap(8'd3, 16'h0042);
    step(1);
    ctrl_in = 16'h0000;
    step(4);

    // snap edge coinciding with freeze counts once
    ctrl_in = 16'h0003; push_cap(8'd4, 16'h0042);
    step(6);
    ctrl_in = 16'h0000;
    step(4);
    @(negedge clock);
    chk("coincide_cnt", snap_count, 8'd4);

    // sticky accumulate and clear
    step(1);
    st0 = 16'h0000;
    step(1);
    ctrl_in = 16'h0004;
    step(1);
    ctrl_in = 16'h0000;
    step(3);
    @(negedge clock);
    chk("sticky_clr0", sticky_out, 16'h0000);
    step(1);
    st0 = 16'h0001;
    step(1);
    st0 = 16'h0100;
    step(1);
    st0 = 16'h0000;
    step(2);
    @(negedge clock);
    chk("sticky_acc", sticky_out, 16'h0101);
    step(1);
    st0 = 16'h0010;
    step(2);
    @(negedge clock);
    chk("sticky_acc2", sticky_out, 16'h0111);
    step(1);
    ctrl_in = 16'h0004;
    step(1);
    ctrl_in = 16'h0000;
    step(3);
    @(negedge clock);
    chk("sticky_clr", sticky_out, 16'h0010);

    // manual LED select with clamp
    step(1);
    st1 = 16'h000F; ctrl_in = 16'h0010;
    step(5);
    @(negedge clock);
    chk("led_sel1", lights, 8'hF0);
    step(1);
    ctrl_in = 16'h0050;
    step(5);
    @(negedge clock);
    chk("led_clamp", lights, 8'h10);
    step(1);
    ctrl_in = 16'h0000;
    step(5);
    @(negedge clock);
    chk("led_sel0", lights, 8'hEF);

    // auto scan: runs of 4 cycles per channel, 0 -> 1 -> 2 -> 0
    step(1);
    ctrl_in = 16'h0100;
    nr = 0;
    for (int i = 0; i < 24; i++) begin
      @(negedge clock);
      s = lights;
      if (nr == 0 || rv[nr-1] != s) begin
        rv[nr] = s;
        rl[nr] = 1;
        nr++;
      end else begin
        rl[nr-1]++;
      end
    end
    chk("scan_nruns", nr >= 5, 1'b1);
    chk("scan_v0", rv[0], 8'hEF);
    chk("scan_v1", rv[1], 8'hF0);
    chk("scan_l1", rl[1], 4);
    chk("scan_v2", rv[2], 8'h10);
    chk("scan_l2", rl[2], 4);
    chk("scan_v3", rv[3], 8'hEF);
    chk("scan_l3", rl[3], 4);
    chk("scan_v4", rv[4], 8'hF0);
    step(1);
    ctrl_in = 16'h0000;
    step(5);
    @(negedge clock);
    chk("auto_off", lights, 8'hEF);

    for (int i = 0; i < 20 && cap_q.size() != 0; i++) @(negedge clock);
    chk("sb_drain", cap_q.size(), 0);

    // reset wins over an in-flight capture
    step(1);
    ctrl_in = 16'h0002;
    step(1);
    resetn = 1'b0;
    ctrl_in = 16'h0000;
    step(2);
    @(negedge clock);
    chk("rstcap_done", snap_done, 1'b0);
    chk("rstcap_cnt", snap_count, 8'd0);
    chk("rstcap_wire", wire_out, '0);
    step(1);
    resetn = 1'b1;
    step(3);
    @(negedge clock);
    chk("rstcap_cnt2", snap_count, 8'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
